// File: rtl/dbg_pkg.sv
// Shared constants for the debug probe scanner: scan modes and default widths.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package dbg_pkg;

  // Scan mode encodings on the 2-bit mode input
  localparam logic [1:0] MODE_AUTO   = 2'b00;
  localparam logic [1:0] MODE_HOLD   = 2'b01;
  localparam logic [1:0] MODE_STEP   = 2'b10;
  localparam logic [1:0] MODE_DIRECT = 2'b11;

  // Default geometry
  localparam int DEF_XLEN  = 32;
  localparam int DEF_CH_W  = 4;
  localparam int DEF_TAG_W = 4;

  // The tag shown is channel+1, so a zero tag never names a real channel.
  // Tags stay unique only while NCH <= 2**TAG_W - 1.
  function automatic int tag_w_min(input int nch);
    return $clog2(nch + 1);
  endfunction

  localparam int TAG_MAX_NCH = (1 << DEF_TAG_W) - 1;

endpackage

// File: rtl/dbg_tick_gen.sv
// Prescaler for auto-scan: counts 0..period and pulses tick_o at the terminal count.
// Latency: tick_o is combinational from the count, so it can be consumed in the same cycle.
// Backpressure: none; counting freezes (and tick_o stays low) unless enabled in auto mode.
module dbg_tick_gen
  import dbg_pkg::*;
#(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] period,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt;
  logic             run;

  // Run gating and terminal-count detect; rstn masks the pulse while in reset
  always_comb begin
    run    = en && (mode == MODE_AUTO);
    tick_o = rstn && run && (cnt == period);
  end

  // Counter: clears on terminal count, otherwise wraps freely through 2**DIV_W
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == period) ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/dbg_probe_scanner.sv
// Debug display scanner: picks one of NCH probe words per step, tags it with channel+1, registers it.
// Latency: data_o/ch_o reflect the pointer and probes of the previous cycle (1 register stage).
// Backpressure: none; en=0 freezes pointer and outputs and drops valid_o. Option: DBG_SNAPSHOT_EN.
module dbg_probe_scanner
  import dbg_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NCH   = 8,
  parameter int CH_W  = DEF_CH_W,
  parameter int TAG_W = DEF_TAG_W,
  parameter int DIV_W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic                step,
  input  logic [CH_W-1:0]     sel,
  input  logic [CH_W-1:0]     last_ch,
  input  logic [DIV_W-1:0]    period,
  input  logic [NCH*XLEN-1:0] probe_i,
`ifdef DBG_SNAPSHOT_EN
  input  logic                snap,
`endif
  output logic [XLEN-1:0]     data_o,
  output logic [CH_W-1:0]     ch_o,
  output logic                tick_o,
  output logic                valid_o
);

  // Pad the probe array to a power of two so the pointer can index it directly
  localparam int              NSLOT  = 1 << CH_W;
  localparam logic [CH_W-1:0] TOP_CH = CH_W'(NCH - 1);

  logic [CH_W-1:0]  ptr;
  logic [CH_W-1:0]  ptr_nxt;
  logic [CH_W-1:0]  ptr_adv;
  logic [CH_W-1:0]  sel_clamp;
  logic [CH_W-1:0]  lw;
  logic [CH_W:0]    ptr_p1;
  logic [TAG_W-1:0] tag;
  logic             step_q;
  logic             step_edge;
  logic [XLEN-1:0]  live_arr [NSLOT];
  logic [XLEN-1:0]  src_word;
  logic             unused_tag_bits;

  genvar k;
  generate
    for (k = 0; k < NSLOT; k++) begin : g_live
      if (k < NCH) begin : g_used
        assign live_arr[k] = probe_i[k*XLEN +: XLEN];
      end else begin : g_pad
        assign live_arr[k] = '0;
      end
    end
  endgenerate

  dbg_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk    (clk),
    .rstn   (rstn),
    .en     (en),
    .mode   (mode),
    .period (period),
    .tick_o (tick_o)
  );

  // Pointer next-state: wrap clamp, advance rule and per-mode selection
  always_comb begin
    lw        = (last_ch > TOP_CH) ? TOP_CH : last_ch;
    ptr_adv   = (ptr >= lw) ? '0 : ptr + CH_W'(1);
    sel_clamp = (sel > lw) ? lw : sel;
    step_edge = step & ~step_q;
    ptr_p1    = {1'b0, ptr} + (CH_W+1)'(1);
    tag       = TAG_W'(ptr_p1);
    ptr_nxt   = ptr;
    if (en) begin
      case (mode)
        MODE_AUTO:   if (tick_o) ptr_nxt = ptr_adv;
        MODE_HOLD:   ptr_nxt = ptr;
        MODE_STEP:   if (step_edge) ptr_nxt = ptr_adv;
        MODE_DIRECT: ptr_nxt = sel_clamp;
        default:     ptr_nxt = ptr;
      endcase
    end
  end

`ifdef DBG_SNAPSHOT_EN
  logic            snap_q;
  logic            use_shadow;
  logic [XLEN-1:0] shadow [NSLOT];

  // Snapshot bank: a rising edge of snap freezes every probe at once
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snap_q     <= 1'b0;
      use_shadow <= 1'b0;
      for (int i = 0; i < NSLOT; i++) shadow[i] <= '0;
    end else begin
      snap_q <= snap;
      if (snap && !snap_q) begin
        use_shadow <= 1'b1;
        for (int i = 0; i < NSLOT; i++) shadow[i] <= live_arr[i];
      end
    end
  end

  assign src_word = use_shadow ? shadow[ptr] : live_arr[ptr];
`else
  assign src_word = live_arr[ptr];
`endif

  // The tag overwrites the probe MSBs, so those bits never reach the display
  assign unused_tag_bits = ^src_word[XLEN-1 -: TAG_W];

  // Pointer, step history and display register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr     <= '0;
      step_q  <= 1'b0;
      data_o  <= '0;
      ch_o    <= '0;
      valid_o <= 1'b0;
    end else begin
      step_q <= step;
      ptr    <= ptr_nxt;
      if (en) begin
        data_o  <= {tag, src_word[XLEN-TAG_W-1:0]};
        ch_o    <= ptr;
        valid_o <= 1'b1;
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
